// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input conditioning stage:
// PS/2 scancodes, csjudlr bit positions and the coin FSM state encoding.
package arcade_input_pkg;

    localparam logic [7:0] SC_UP       = 8'h75;  // extended
    localparam logic [7:0] SC_DOWN     = 8'h72;  // extended
    localparam logic [7:0] SC_LEFT     = 8'h6B;  // extended
    localparam logic [7:0] SC_RIGHT    = 8'h74;  // extended
    localparam logic [7:0] SC_FIRE     = 8'h29;
    localparam logic [7:0] SC_FIRE_ALT = 8'h14;  // left ctrl, either variant
    localparam logic [7:0] SC_START1   = 8'h05;
    localparam logic [7:0] SC_START2   = 8'h06;
    localparam logic [7:0] SC_COIN     = 8'h2E;

    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_FIRE  = 4;
    localparam int B_START = 5;
    localparam int B_COIN  = 6;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire;
        logic start1;
        logic start2;
        logic coin;
    } key_state_t;

endpackage

// File: rtl/coin_pulser.sv
// Turns coin request edges into timed, rate-limited coin pulses:
// ms prescaler, saturating pending counter and IDLE/PULSE/GAP FSM.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int CLK_HZ   = 12000000,
    parameter int COIN_MS  = 100,
    parameter int GAP_MS   = 100,
    parameter int MAX_PEND = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req_edge_i,
    input  logic clear_i,
    output logic coin_o,
    output logic busy_o
);

    localparam int         DIV      = CLK_HZ / 1000;
    localparam int         PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [7:0] COIN_T   = 8'(COIN_MS);
    localparam logic [7:0] GAP_T    = 8'(GAP_MS);
    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

    logic [PW-1:0] presc_q;
    logic          ms_tick;

    coin_state_t   state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [1:0]    pend_q, pend_d;
    logic          take;

    assign ms_tick = (presc_q == PW'(DIV - 1));

    // The prescaler is never cleared so the ms grid stays phase-stable.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            presc_q <= ms_tick ? '0 : presc_q + 1'b1;
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state_q;
        timer_d = timer_q;
        take    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_q != 2'd0) begin
                    state_d = PULSE;
                    timer_d = COIN_T;
                    take    = 1'b1;
                end
            end
            PULSE: begin
                if (ms_tick) begin
                    if (timer_q == 8'd1) begin
                        state_d = GAP;
                        timer_d = GAP_T;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            GAP: begin
                if (ms_tick) begin
                    if (timer_q == 8'd1) begin
                        state_d = IDLE;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 8'd0;
            end
        endcase

        // A request arriving in the same cycle the FSM consumes one cancels out.
        pend_d = pend_q;
        if (req_edge_i && !take) begin
            if (pend_q != PEND_MAX) pend_d = pend_q + 2'd1;
        end else if (!req_edge_i && take) begin
            pend_d = pend_q - 2'd1;
        end

        if (clear_i) begin
            state_d = IDLE;
            timer_d = 8'd0;
            pend_d  = 2'd0;
        end
    end

    assign coin_o = (state_q == PULSE);
    assign busy_o = (state_q != IDLE) || (pend_q != 2'd0);

endmodule

// File: rtl/arcade_input_ctrl.sv
// Input conditioning for the galaxian core: PS/2 key decode, joystick merge,
// orientation remap and coin pulse generation, all in clk_sys.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int COIN_MS   = 100,
    parameter int GAP_MS    = 100,
    parameter int MAX_PEND  = 3,
    parameter int AUTO_COIN = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        orient,
    input  logic        clear,
    output logic [6:0]  p1_csjudlr,
    output logic [6:0]  p2_csjudlr,
    output logic        coin_busy
);

    localparam logic AUTO = (AUTO_COIN != 0);

    logic       tog_q;
    key_state_t keys_q, keys_d;
    logic [5:0] p1_q, p1_d;
    logic [5:0] p2_q, p2_d;
    logic       st1_q, st2_q, coinreq_q;

    logic        ps2_event, ps2_pressed, ps2_ext;
    logic [7:0]  ps2_code;
    logic [15:0] j;
    logic        raw_u, raw_d, raw_l, raw_r;
    logic        up, down, left, right;
    logic        fire, st1, st2, coinreq;
    logic        req_edge, coin;
    logic        unused_j;

    assign ps2_event   = ps2_key[10] ^ tog_q;
    assign ps2_pressed = ps2_key[9];
    assign ps2_ext     = ps2_key[8];
    assign ps2_code    = ps2_key[7:0];

    always_comb begin
        keys_d = keys_q;
        if (ps2_event) begin
            case (ps2_code)
                SC_UP:       if (ps2_ext)  keys_d.up     = ps2_pressed;
                SC_DOWN:     if (ps2_ext)  keys_d.down   = ps2_pressed;
                SC_LEFT:     if (ps2_ext)  keys_d.left   = ps2_pressed;
                SC_RIGHT:    if (ps2_ext)  keys_d.right  = ps2_pressed;
                SC_FIRE:     if (!ps2_ext) keys_d.fire   = ps2_pressed;
                SC_FIRE_ALT:               keys_d.fire   = ps2_pressed;
                SC_START1:   if (!ps2_ext) keys_d.start1 = ps2_pressed;
                SC_START2:   if (!ps2_ext) keys_d.start2 = ps2_pressed;
                SC_COIN:     if (!ps2_ext) keys_d.coin   = ps2_pressed;
                default: ;
            endcase
        end
        if (clear) keys_d = '0;
    end

    assign j        = joystick_0 | joystick_1;
    assign unused_j = ^j[15:8];

    always_comb begin
        raw_u = keys_q.up    | j[3];
        raw_d = keys_q.down  | j[2];
        raw_l = keys_q.left  | j[1];
        raw_r = keys_q.right | j[0];

        // Horizontal cabinets rotate the stick a quarter turn.
        if (orient) begin
            up    = raw_l;
            down  = raw_r;
            left  = raw_d;
            right = raw_u;
        end else begin
            up    = raw_u;
            down  = raw_d;
            left  = raw_l;
            right = raw_r;
        end

        fire    = keys_q.fire   | j[4];
        st1     = keys_q.start1 | j[5];
        st2     = keys_q.start2 | j[6];
        coinreq = keys_q.coin   | j[7];

        p1_d = '0;
        p1_d[B_RIGHT] = right;
        p1_d[B_LEFT]  = left;
        p1_d[B_DOWN]  = down;
        p1_d[B_UP]    = up;
        p1_d[B_FIRE]  = fire;
        p1_d[B_START] = st1;

        p2_d = p1_d;
        p2_d[B_START] = st2;
    end

    assign req_edge = (coinreq & ~coinreq_q)
                    | (AUTO & ((st1 & ~st1_q) | (st2 & ~st2_q)));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            keys_q    <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            st1_q     <= 1'b0;
            st2_q     <= 1'b0;
            coinreq_q <= 1'b0;
        end else begin
            tog_q  <= ps2_key[10];
            keys_q <= keys_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            if (clear) begin
                st1_q     <= 1'b0;
                st2_q     <= 1'b0;
                coinreq_q <= 1'b0;
            end else begin
                st1_q     <= st1;
                st2_q     <= st2;
                coinreq_q <= coinreq;
            end
        end
    end

    coin_pulser #(
        .CLK_HZ  (CLK_HZ),
        .COIN_MS (COIN_MS),
        .GAP_MS  (GAP_MS),
        .MAX_PEND(MAX_PEND)
    ) u_coin_pulser (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .req_edge_i(req_edge),
        .clear_i   (clear),
        .coin_o    (coin),
        .busy_o    (coin_busy)
    );

    // Coin bypasses the output register so clear drops it on the very next edge.
    assign p1_csjudlr = {coin, p1_q};
    assign p2_csjudlr = {1'b0, p2_q};

endmodule
